// File: rtl/aoc_delivery_pkg.sv
// Shared constants and types for the delivery-walk tracker.
// Sweep logic is enabled by AOC_DELIVERY_TRACKER_MEM_CLEAR_EN.
package aoc_delivery_pkg;

    localparam int DEF_COORD_WIDTH  = 9;
    localparam int DEF_RESULT_WIDTH = 32;

    localparam logic [7:0] CHAR_UP    = 8'h5E;
    localparam logic [7:0] CHAR_DOWN  = 8'h76;
    localparam logic [7:0] CHAR_LEFT  = 8'h3C;
    localparam logic [7:0] CHAR_RIGHT = 8'h3E;
    localparam logic [7:0] CHAR_LF    = 8'h0A;

    typedef logic signed [DEF_COORD_WIDTH-1:0] coord_t;
    typedef logic [DEF_RESULT_WIDTH-1:0] result_t;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } clr_state_t;

endpackage

// File: rtl/jtag_dr_shifter.sv
// LSB-first JTAG data register with optional parallel load.
// Load wins over shift; both are gated by the caller.
module jtag_dr_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             tck,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    input  logic             tdi,
    output logic [WIDTH-1:0] q
);

    // Capture a parallel value or shift tdi in at the MSB.
    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load_en) begin
            q <= load_val;
        end else if (shift_en) begin
            q <= {tdi, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/aoc_delivery_tracker.sv
// Counts distinct grid cells visited by a courier fed over JTAG.
// AOC_DELIVERY_TRACKER_MEM_CLEAR_EN adds a post-reset bitmap sweep.
module aoc_delivery_tracker
    import aoc_delivery_pkg::*;
#(
    parameter int COORD_WIDTH  = DEF_COORD_WIDTH,
    parameter int RESULT_WIDTH = DEF_RESULT_WIDTH
) (
    input  logic tck,
    input  logic test_logic_reset,
    input  logic tdi,
    output logic tdo,
    input  logic run_test_idle,
    input  logic ir_is_user,
    input  logic capture_dr,
    input  logic shift_dr,
    input  logic update_dr
);

    localparam int AW = 2 * COORD_WIDTH;
    localparam logic [COORD_WIDTH-1:0] HALF =
        {1'b1, {(COORD_WIDTH-1){1'b0}}};
    localparam logic [AW-1:0] ORIGIN = {HALF, HALF};
    localparam logic signed [COORD_WIDTH-1:0] ONE =
        {{(COORD_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [RESULT_WIDTH-1:0] CNT_ONE =
        {{(RESULT_WIDTH-1){1'b0}}, 1'b1};

    logic unused_rti;
    assign unused_rti = run_test_idle;

    logic [7:0]              in_q;
    logic [RESULT_WIDTH-1:0] out_q;
    logic [RESULT_WIDTH-1:0] cap_val;
    logic                    run_ok;

    logic [7:0] char_q;
    logic       char_vld;

    logic signed [COORD_WIDTH-1:0] x, y, nx, ny;
    logic                          mv, lf, done;
    logic                          s0_vld, s1_vld;
    logic [AW-1:0]                 pos_addr, s1_addr;
    logic [COORD_WIDTH-1:0]        xa, ya;

    logic          mem [2**AW];
    logic          rd_bit;
    logic [AW-1:0] ram_addr;
    logic          ram_we, ram_wd, visit_we;

    logic [RESULT_WIDTH-1:0] count;
    logic                    done_drained;

    jtag_dr_shifter #(.WIDTH(8)) u_in_sr (
        .tck      (tck),
        .rst      (test_logic_reset),
        .shift_en (ir_is_user && shift_dr),
        .load_en  (1'b0),
        .load_val (8'h00),
        .tdi      (tdi),
        .q        (in_q)
    );

    jtag_dr_shifter #(.WIDTH(RESULT_WIDTH)) u_out_sr (
        .tck      (tck),
        .rst      (test_logic_reset),
        .shift_en (ir_is_user && shift_dr),
        .load_en  (ir_is_user && capture_dr),
        .load_val (cap_val),
        .tdi      (tdi),
        .q        (out_q)
    );

    assign tdo = out_q[0];

`ifdef AOC_DELIVERY_TRACKER_MEM_CLEAR_EN
    clr_state_t    state;
    logic [AW-1:0] clr_addr;

    // Sweep every bitmap cell once after reset, then accept input.
    always_ff @(posedge tck or posedge test_logic_reset) begin
        if (test_logic_reset) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
            if (&clr_addr) state <= ST_RUN;
        end
    end

    assign run_ok = (state == ST_RUN);
`else
    assign run_ok = 1'b1;
`endif

    // Latch the scanned byte as a one-cycle character strobe.
    always_ff @(posedge tck or posedge test_logic_reset) begin
        if (test_logic_reset) begin
            char_q   <= '0;
            char_vld <= 1'b0;
        end else begin
            char_vld <= ir_is_user && update_dr && run_ok;
            if (ir_is_user && update_dr) char_q <= in_q;
        end
    end

    // Decode one character into a unit step.
    always_comb begin
        nx = x;
        ny = y;
        mv = 1'b0;
        lf = 1'b0;
        unique case (char_q)
            CHAR_UP:    begin ny = y + ONE; mv = 1'b1; end
            CHAR_DOWN:  begin ny = y - ONE; mv = 1'b1; end
            CHAR_RIGHT: begin nx = x + ONE; mv = 1'b1; end
            CHAR_LEFT:  begin nx = x - ONE; mv = 1'b1; end
            CHAR_LF:    lf = 1'b1;
            default:    ;
        endcase
    end

    // S0: register the new position, or the sticky done flag.
    always_ff @(posedge tck or posedge test_logic_reset) begin
        if (test_logic_reset) begin
            x      <= '0;
            y      <= '0;
            done   <= 1'b0;
            s0_vld <= 1'b0;
        end else begin
            s0_vld <= 1'b0;
            if (char_vld && !done) begin
                if (lf) begin
                    done <= 1'b1;
                end else if (mv) begin
                    x      <= nx;
                    y      <= ny;
                    s0_vld <= 1'b1;
                end
            end
        end
    end

    assign xa       = $unsigned(x) + HALF;
    assign ya       = $unsigned(y) + HALF;
    assign pos_addr = {xa, ya};

    // S1: remember which cell is being read.
    always_ff @(posedge tck or posedge test_logic_reset) begin
        if (test_logic_reset) begin
            s1_vld  <= 1'b0;
            s1_addr <= '0;
        end else begin
            s1_vld <= s0_vld;
            if (s0_vld) s1_addr <= pos_addr;
        end
    end

    // The origin always counts as visited, even with a blank bitmap.
    assign visit_we = s1_vld && !rd_bit && (s1_addr != ORIGIN);

    // Single shared RAM address: read in S1, write in S2 or sweep.
    always_comb begin
        ram_addr = s1_vld ? s1_addr : pos_addr;
        ram_we   = visit_we;
        ram_wd   = 1'b1;
`ifdef AOC_DELIVERY_TRACKER_MEM_CLEAR_EN
        if (state == ST_CLEAR) begin
            ram_addr = clr_addr;
            ram_we   = 1'b1;
            ram_wd   = (clr_addr == ORIGIN);
        end
`endif
    end

    // Visited bitmap; contents survive reset by design.
    always_ff @(posedge tck) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wd;
        end else begin
            rd_bit <= mem[ram_addr];
        end
    end

    // S2: bump the saturating count for each first visit.
    always_ff @(posedge tck or posedge test_logic_reset) begin
        if (test_logic_reset) begin
            count <= CNT_ONE;
        end else if (visit_we && !(&count)) begin
            count <= count + 1'b1;
        end
    end

    assign done_drained = done && !char_vld && !s0_vld && !s1_vld;
    assign cap_val = (done_drained && run_ok) ? count : '0;

endmodule

// File: tb/tb_aoc_delivery_tracker.sv
// Randomised self-checking bench for aoc_delivery_tracker.
// Honours AOC_DELIVERY_TRACKER_MEM_CLEAR_EN for bitmap persistence.
module tb_aoc_delivery_tracker;
    import aoc_delivery_pkg::*;

    localparam int CW   = DEF_COORD_WIDTH;
    localparam int MASK = (1 << CW) - 1;
    localparam int HALFI = 1 << (CW - 1);

    logic tck = 1'b0;
    logic test_logic_reset = 1'b1;
    logic tdi = 1'b0;
    logic tdo;
    logic run_test_idle = 1'b0;
    logic ir_is_user = 1'b0;
    logic capture_dr = 1'b0;
    logic shift_dr = 1'b0;
    logic update_dr = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    int     mx, my;
    longint mcount;
    bit     mdone;
    bit     visited [int];
    logic [31:0] shifted_in;

    aoc_delivery_tracker dut (
        .tck              (tck),
        .test_logic_reset (test_logic_reset),
        .tdi              (tdi),
        .tdo              (tdo),
        .run_test_idle    (run_test_idle),
        .ir_is_user       (ir_is_user),
        .capture_dr       (capture_dr),
        .shift_dr         (shift_dr),
        .update_dr        (update_dr)
    );

    always #5 tck = ~tck;

    function automatic int cell_key(input int cx, input int cy);
        return (((cx + HALFI) & MASK) << CW) | ((cy + HALFI) & MASK);
    endfunction

    task automatic model_reset();
        mx = 0;
        my = 0;
        mcount = 1;
        mdone = 1'b0;
`ifdef AOC_DELIVERY_TRACKER_MEM_CLEAR_EN
        visited.delete();
`endif
        visited[cell_key(0, 0)] = 1'b1;
    endtask

    task automatic model_char(input logic [7:0] c);
        bit moved;
        int k;
        moved = 1'b1;
        if (mdone) return;
        if (c == 8'h5E)      my = (my + 1) & MASK;
        else if (c == 8'h76) my = (my - 1) & MASK;
        else if (c == 8'h3E) mx = (mx + 1) & MASK;
        else if (c == 8'h3C) mx = (mx - 1) & MASK;
        else begin
            moved = 1'b0;
            if (c == 8'h0A) mdone = 1'b1;
        end
        if (moved) begin
            k = cell_key(mx, my);
            if (!visited.exists(k)) begin
                visited[k] = 1'b1;
                if (mcount < 64'hFFFF_FFFF) mcount++;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge tck);
        test_logic_reset = 1'b1;
        ir_is_user = 1'b0;
        shift_dr = 1'b0;
        capture_dr = 1'b0;
        update_dr = 1'b0;
        repeat (2) @(negedge tck);
        test_logic_reset = 1'b0;
        model_reset();
`ifdef AOC_DELIVERY_TRACKER_MEM_CLEAR_EN
        repeat ((1 << (2 * CW)) + 8) @(negedge tck);
`else
        repeat (2) @(negedge tck);
`endif
    endtask

    task automatic send(input logic [7:0] c, input bit user);
        for (int i = 0; i < 8; i++) begin
            @(negedge tck);
            ir_is_user = user;
            shift_dr = 1'b1;
            tdi = c[i];
        end
        @(negedge tck);
        shift_dr = 1'b0;
        update_dr = 1'b1;
        @(negedge tck);
        update_dr = 1'b0;
        ir_is_user = 1'b0;
        repeat (12) @(negedge tck);
        if (user) model_char(c);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b1);
    endtask

    task automatic poll(output logic [31:0] v, input logic [31:0] pat);
        @(negedge tck);
        ir_is_user = 1'b1;
        capture_dr = 1'b1;
        @(negedge tck);
        capture_dr = 1'b0;
        shift_dr = 1'b1;
        for (int i = 0; i < 32; i++) begin
            v[i] = tdo;
            tdi = pat[i];
            @(negedge tck);
        end
        shift_dr = 1'b0;
        ir_is_user = 1'b0;
        shifted_in = pat;
    endtask

    task automatic check_poll(input string name);
        logic [31:0] v;
        logic [31:0] exp;
        poll(v, $urandom);
        exp = mdone ? mcount[31:0] : 32'd0;
        n_cmp++;
        if (v !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, v, exp);
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        apply_reset();
        n_cmp++;
        if (tdo !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tdo: got %b expected 0", tdo);
        end
        check_poll("reset_poll");
        poll(v, 32'hFFFF_FFFF);
        @(negedge tck);
        test_logic_reset = 1'b1;
        #1;
        n_cmp++;
        if (tdo !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async_tdo: got %b expected 0", tdo);
        end
        @(negedge tck);
        test_logic_reset = 1'b0;
        apply_reset();
    endtask

    task automatic test_basic();
        apply_reset();
        send_str(">");
        send(CHAR_LF, 1'b1);
        check_poll("right_lf");
        apply_reset();
        send_str("^>v<");
        send(CHAR_LF, 1'b1);
        check_poll("square");
        apply_reset();
        send_str("^v^v^v^v^v");
        send(CHAR_LF, 1'b1);
        check_poll("updown");
    endtask

    task automatic test_poll_early();
        apply_reset();
        send_str(">>>");
        check_poll("early_poll");
        send(CHAR_LF, 1'b1);
        check_poll("late_poll");
    endtask

    task automatic test_mid_reset();
        apply_reset();
        send_str("^>v<");
        apply_reset();
        check_poll("mid_reset_zero");
        send_str(">");
        send(CHAR_LF, 1'b1);
        check_poll("mid_reset_walk");
    endtask

    task automatic test_junk_and_gating();
        logic [31:0] v;
        logic        t_exp;
        apply_reset();
        send(8'h61, 1'b1);
        send(8'h0D, 1'b1);
        send(CHAR_UP, 1'b1);
        send(CHAR_LF, 1'b1);
        check_poll("junk");
        send(CHAR_RIGHT, 1'b0);
        send(CHAR_DOWN, 1'b0);
        check_poll("gated_chars");
        send(CHAR_LEFT, 1'b1);
        send(CHAR_DOWN, 1'b1);
        check_poll("after_done");
        poll(v, $urandom);
        t_exp = shifted_in[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge tck);
            capture_dr = i[0];
            shift_dr = 1'b1;
            tdi = ~t_exp;
        end
        @(negedge tck);
        shift_dr = 1'b0;
        capture_dr = 1'b0;
        n_cmp++;
        if (tdo !== t_exp) begin
            n_fail++;
            $display("FAIL gated_shift_tdo: got %b expected %b", tdo, t_exp);
        end
    endtask

    task automatic test_random();
        logic [7:0] set [6];
        string      nm;
        int         len;
        set[0] = CHAR_UP;
        set[1] = CHAR_DOWN;
        set[2] = CHAR_LEFT;
        set[3] = CHAR_RIGHT;
        set[4] = 8'h0D;
        set[5] = 8'h41;
        for (int r = 0; r < 6; r++) begin
            apply_reset();
            len = $urandom_range(24, 4);
            for (int i = 0; i < len; i++) begin
                send(set[$urandom_range(5, 0)], 1'b1);
                if ($urandom_range(7, 0) == 0) begin
                    nm = $sformatf("rand%0d_mid", r);
                    check_poll(nm);
                end
            end
            send(CHAR_LF, 1'b1);
            nm = $sformatf("rand%0d_final", r);
            check_poll(nm);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        send(CHAR_UP, 1'b1);
        send(CHAR_UP, 1'b1);
        for (int i = 0; i < (1 << CW) + 3; i++) send(CHAR_RIGHT, 1'b1);
        send(CHAR_LF, 1'b1);
        check_poll("wrap_row");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_poll_early();
        test_mid_reset();
        test_junk_and_gating();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/aoc_delivery_tracker.md
Name: aoc_delivery_tracker

Overview:
- JTAG-attached accelerator for the "houses visited" grid walk: a single courier starts at the origin and moves one cell per direction character (^ v < >); the block counts distinct cells visited at least once, including the origin.
- Sits behind a BSCAN USER4 instruction. Characters stream in one 8-bit DR scan each. A 32-bit DR scan reads the result back.
- Runs entirely in the tck domain.

Parameters:
- COORD_WIDTH, 9, bits per axis; the grid is 2^COORD_WIDTH × 2^COORD_WIDTH cells, with the origin at the centre.
- RESULT_WIDTH, 32, width of the count and of the readback scan.

Ports:
- tck  input  1  JTAG clock; every flop uses the rising edge.
- test_logic_reset  input  1  asynchronous, active-high reset.
- tdi  input  1  serial data in.
- tdo  output  1  serial data out; equals readback shift register bit 0 (combinational).
- run_test_idle  input  1  TAP in Run-Test/Idle; informational, unused.
- ir_is_user  input  1  USER4 selected; all DR actions are gated by it.
- capture_dr  input  1  TAP Capture-DR.
- shift_dr  input  1  TAP Shift-DR.
- update_dr  input  1  TAP Update-DR.

Behaviour:
- Reset values:
  - position = (0,0); count = 1; done = 0.
  - Input and readback shift registers = 0; tdo = 0.
  - Pipeline valid flags = 0.
- Input path:
  - While ir_is_user && shift_dr: in_sr <= {tdi, in_sr[7:1]} (LSB first).
  - On ir_is_user && update_dr: the 8-bit in_sr is presented as one character, with a one-cycle valid.
- Decode:
  - 0x5E '^' → y+1; 0x76 'v' → y−1; 0x3E '>' → x+1; 0x3C '<' → x−1.
  - 0x0A sets done; done is sticky until reset.
  - All other bytes (including 0x0D) are ignored.
  - Characters arriving after done are ignored.
- Coordinate arithmetic:
  - Two's-complement, COORD_WIDTH bits, wraps modulo 2^COORD_WIDTH. Aliasing beyond that range is accepted.
  - Bitmap address = {x + 2^(COORD_WIDTH−1), y + 2^(COORD_WIDTH−1)}.
- Visit pipeline (3 stages):
  - S0: new position registered.
  - S1: synchronous bitmap read of the new cell.
  - S2: if the bit is 0, write 1 and count <= count + 1.
- Pipeline rules:
  - The origin bit is treated as already visited (count starts at 1). The origin cell is pre-set at configuration.
  - Characters arrive at least 10 tck apart, so no hazard forwarding is required.
  - The pipeline must drain before done is reflected in readback.
- Bitmap: 2^(2·COORD_WIDTH) × 1 bit single-port RAM, zero-initialised at configuration except the origin; it is not cleared by reset (see optional feature).
- Readback path:
  - On ir_is_user && capture_dr: out_sr <= done_drained ? count : 0.
  - While ir_is_user && shift_dr: out_sr <= {tdi, out_sr[RESULT_WIDTH-1:1]}.
  - The host polls until it reads a nonzero value.
- Boundaries:
  - count saturates at 2^RESULT_WIDTH − 1.
  - Reset mid-stream aborts the walk and restores the reset values above.
  - capture_dr and update_dr are never simultaneous.
  - With ir_is_user = 0, no register changes.

Optional Feature:
- Macro: AOC_DELIVERY_TRACKER_MEM_CLEAR_EN.
- Defined:
  - After reset deasserts, a sweep FSM (CLEAR → RUN) clears the bitmap one cell per tck, then sets the origin bit.
  - Characters presented during CLEAR are dropped, and capture returns 0 until CLEAR completes.
- Undefined: the bitmap relies only on configuration initial contents, and no sweep logic exists.

Decomposition:
- Package aoc_delivery_pkg:
  - Character constants CHAR_UP, CHAR_DOWN, CHAR_LEFT, CHAR_RIGHT, CHAR_LF.
  - Typedef coord_t (signed COORD_WIDTH).
  - Typedef result_t.
- One sub-module, jtag_dr_shifter, parameterised by width. It is instantiated twice: 8-bit input and RESULT_WIDTH readback.
- Bitmap RAM is inferred inline.

Test Plan:
- Stream ">" then LF, then poll a 32-bit scan → 2.
- Stream "^>v<" then LF → 4.
- Stream "^v^v^v^v^v" then LF → 2.
- Poll before sending LF after ">>>" → 0. Then send LF and poll → 4.
- Stream "^>v<", assert test_logic_reset, then stream ">" and LF → 2 (with MEM_CLEAR_EN, after the sweep completes).
- Mixed junk "a\r^" then LF → 2; shifting with ir_is_user = 0 leaves the result unchanged.
